rambus_initiator: RTL and testbench

- Fabric-side initiator for the RamBus register interface exported by DMMainPorts. It drives the same select, latch, write, address and data inputs that the MSS APB slave port normally drives.
- It lets fabric logic (sequencers, self-test, simulation benches) issue single register reads and writes to DMMainPorts without the MSS.
- Each command is one two-phase transfer (setup, then access) that waits for RamBusAck. An access that gets no Ack is ended by a timeout.

---
 rtl/rambus_initiator.sv | 140 ++++++++++++++
 tb/tb_rambus_initiator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_initiator.sv
// Fabric-side RamBus initiator: one SETUP+ACCESS transfer per command, 3 cycles accept->RspValid with an immediate Ack.
// CmdReady is high only in IDLE; RspValid is a single-cycle pulse with no backpressure.
module rambus_initiator #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [ADDR_WIDTH-1:0] CmdAddress,
  input  logic [DATA_WIDTH-1:0] CmdData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspTimeout,
  output logic                  RamBusnCs,
  output logic                  RamBusWrnRd,
  output logic                  RamBusLatch,
  output logic [ADDR_WIDTH-1:0] RamBusAddress,
  output logic [DATA_WIDTH-1:0] RamBusDataIn,
  input  logic                  RamBusAck,
  input  logic [DATA_WIDTH-1:0] RamBusDataOut
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic                    load_cmd;
  logic                    rsp_load;
  logic [DATA_WIDTH-1:0]   rsp_data_d;
  logic                    rsp_to_d;

  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_cmd    = 1'b0;
    rsp_load    = 1'b0;
    rsp_data_d  = '0;
    rsp_to_d    = 1'b0;
    CmdReady    = 1'b0;
    RspValid    = 1'b0;
    RamBusnCs   = 1'b0;
    RamBusLatch = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so the accept handshake is dead while reset is held.
        CmdReady = ~rst;
        if (CmdValid) begin
          load_cmd = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        RamBusnCs = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        RamBusnCs   = 1'b1;
        RamBusLatch = 1'b1;
        // Ack takes priority over the timeout boundary on the same edge.
        if (RamBusAck) begin
          rsp_load   = 1'b1;
          rsp_data_d = wr_q ? '0 : RamBusDataOut;
          state_d    = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_load = 1'b1;
          rsp_to_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        RspValid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command registers drive the bus and hold through DONE until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_cmd) begin
      wr_q    <= CmdWrite;
      addr_q  <= CmdAddress;
      wdata_q <= CmdWrite ? CmdData : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else if (rsp_load) begin
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  assign RamBusWrnRd   = wr_q;
  assign RamBusAddress = addr_q;
  assign RamBusDataIn  = wdata_q;
  assign RspData       = rsp_data_q;
  assign RspTimeout    = rsp_to_q;

endmodule

// File: tb/tb_rambus_initiator.sv
// Bench for rambus_initiator: directed and randomized commands against a latency/response model.
module tb_rambus_initiator;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          CmdValid;
  logic          CmdReady;
  logic          CmdWrite;
  logic [AW-1:0] CmdAddress;
  logic [DW-1:0] CmdData;
  logic          RspValid;
  logic [DW-1:0] RspData;
  logic          RspTimeout;
  logic          RamBusnCs;
  logic          RamBusWrnRd;
  logic          RamBusLatch;
  logic [AW-1:0] RamBusAddress;
  logic [DW-1:0] RamBusDataIn;
  logic          RamBusAck;
  logic [DW-1:0] RamBusDataOut;

  int errs   = 0;
  int checks = 0;

  rambus_initiator #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdWrite     (CmdWrite),
    .CmdAddress   (CmdAddress),
    .CmdData      (CmdData),
    .RspValid     (RspValid),
    .RspData      (RspData),
    .RspTimeout   (RspTimeout),
    .RamBusnCs    (RamBusnCs),
    .RamBusWrnRd  (RamBusWrnRd),
    .RamBusLatch  (RamBusLatch),
    .RamBusAddress(RamBusAddress),
    .RamBusDataIn (RamBusDataIn),
    .RamBusAck    (RamBusAck),
    .RamBusDataOut(RamBusDataOut)
  );

  always #5 clk = ~clk;

  // Model: Ack on access cycle d (0-based) completes if d < TO, otherwise the
  // transfer times out after TO access cycles. k counts cycles after the accept edge.
  task automatic run_cmd(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdat, input logic [DW-1:0] rdat,
                         input int delay, input logic setup_ack);
    int            done_k;
    int            w;
    logic          exp_to;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_din;
    logic [46:0]   got;
    logic [46:0]   exp;
    if (delay < TO) begin
      done_k   = delay + 3;
      exp_to   = 1'b0;
      exp_data = wr ? '0 : rdat;
    end else begin
      done_k   = TO + 2;
      exp_to   = 1'b1;
      exp_data = '0;
    end
    exp_din = wr ? wdat : '0;
    w = 0;
    while (CmdReady !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (CmdReady !== 1'b1) begin
      errs++;
      $display("FAIL %s ready: got %b want 1", tag, CmdReady);
      return;
    end
    CmdValid = 1'b1; CmdWrite = wr; CmdAddress = addr; CmdData = wdat;
    RamBusAck = 1'b0;
    RamBusDataOut = rdat;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      // Command inputs are garbage after accept; the DUT must ignore them.
      CmdValid = 1'($urandom); CmdWrite = 1'($urandom);
      CmdAddress = AW'($urandom); CmdData = $urandom;
      RamBusAck = (k == 1) ? setup_ack : ((k - 2) == delay);
      RamBusDataOut = ((k - 2) == delay) ? rdat : $urandom;
      got = {CmdReady, RamBusnCs, RamBusLatch, RspValid, RamBusWrnRd, RamBusAddress, RamBusDataIn};
      if (k < done_k) exp = {1'b0, 1'b1, (k > 1), 1'b0, wr, addr, exp_din};
      else            exp = {1'b0, 1'b0, 1'b0, 1'b1, wr, addr, exp_din};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL %s bus cyc%0d: got %h want %h", tag, k, got, exp);
      end
      if (k == done_k) begin
        checks++;
        if ({RspData, RspTimeout} !== {exp_data, exp_to}) begin
          errs++;
          $display("FAIL %s rsp: got data=%h to=%b want data=%h to=%b",
                   tag, RspData, RspTimeout, exp_data, exp_to);
        end
      end
    end
    CmdValid = 1'b0;
    RamBusAck = 1'b0;
    @(negedge clk);
    checks++;
    if ({CmdReady, RspValid, RamBusnCs, RamBusLatch, RspData, RspTimeout} !==
        {1'b1, 1'b0, 1'b0, 1'b0, exp_data, exp_to}) begin
      errs++;
      $display("FAIL %s idle_hold: got rdy=%b vld=%b cs=%b lat=%b data=%h to=%b want data=%h to=%b",
               tag, CmdReady, RspValid, RamBusnCs, RamBusLatch, RspData, RspTimeout, exp_data, exp_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddress = '0; CmdData = '0;
    RamBusAck = 1'b0; RamBusDataOut = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn,
         RspData, RspTimeout} !== '0) begin
      errs++;
      $display("FAIL reset_hold: got rdy=%b vld=%b cs=%b lat=%b addr=%h din=%h want all 0",
               CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusAddress, RamBusDataIn);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (CmdReady !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready: got %b want 1", CmdReady);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusAddress, RamBusDataIn} !==
          {1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
        errs++;
        $display("FAIL reset_idle cyc%0d: got rdy=%b vld=%b cs=%b lat=%b addr=%h din=%h",
                 i, CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusAddress, RamBusDataIn);
      end
    end
  endtask

  task automatic test_write();
    run_cmd("write", 1'b1, 10'h004, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 1'b1);
  endtask

  task automatic test_read_wait();
    run_cmd("read_wait", 1'b0, 10'h3FF, 32'h11112222, 32'h12345678, 3, 1'b0);
  endtask

  task automatic test_timeout();
    run_cmd("timeout", 1'b0, 10'h0AA, 32'h0, 32'h87654321, 50, 1'b1);
    run_cmd("timeout_edge", 1'b1, 10'h155, 32'hFEEDF00D, 32'h0, TO, 1'b0);
  endtask

  task automatic test_ack_boundary();
    run_cmd("ack_last", 1'b0, 10'h2C3, 32'h0, 32'hC0FFEE01, TO - 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdAddress = 10'h155; CmdData = 32'hFFFFFFFF;
    RamBusAck = 1'b0; RamBusDataOut = 32'hCAFE0001;
    @(negedge clk);
    CmdValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({RamBusnCs, RamBusLatch} !== 2'b11) begin
      errs++;
      $display("FAIL mid_access: got cs=%b lat=%b want 1 1", RamBusnCs, RamBusLatch);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress, RamBusDataIn,
         RspData, RspTimeout} !== '0) begin
      errs++;
      $display("FAIL mid_reset: got rdy=%b vld=%b cs=%b lat=%b addr=%h want all 0",
               CmdReady, RspValid, RamBusnCs, RamBusLatch, RamBusAddress);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    RamBusAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({CmdReady, RspValid, RamBusnCs, RamBusLatch} !== 4'b1000) begin
        errs++;
        $display("FAIL mid_after cyc%0d: got rdy=%b vld=%b cs=%b lat=%b want 1 0 0 0",
                 i, CmdReady, RspValid, RamBusnCs, RamBusLatch);
      end
      @(negedge clk);
    end
    RamBusAck = 1'b0;
    run_cmd("after_reset", 1'b0, 10'h155, 32'h0, 32'h5A5AF00D, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic          wr [3];
    logic [AW-1:0] ad [3];
    logic [DW-1:0] wd [3];
    logic [DW-1:0] rd [3];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] e;
    int            idx = 0;
    int            seen = 0;
    int            last_acc = -1;
    logic          pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'($urandom); ad[i] = AW'($urandom); wd[i] = $urandom; rd[i] = $urandom;
    end
    wr[0] = 1'b1;
    wr[1] = 1'b0;
    RamBusAck = 1'b1;
    CmdValid = 1'b1; CmdWrite = wr[0]; CmdAddress = ad[0]; CmdData = wd[0];
    for (int c = 0; c < 30; c++) begin
      if (RspValid === 1'b1) begin
        checks++;
        e = (expq.size() > 0) ? expq.pop_front() : 32'hXXXXXXXX;
        if ({RspData, RspTimeout} !== {e, 1'b0}) begin
          errs++;
          $display("FAIL b2b rsp%0d: got data=%h to=%b want data=%h to=0", seen, RspData, RspTimeout, e);
        end
        seen++;
      end
      if (CmdValid && CmdReady) begin
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != 4) begin
            errs++;
            $display("FAIL b2b interval: got %0d want 4", c - last_acc);
          end
        end
        last_acc = c;
        expq.push_back(wr[idx] ? '0 : rd[idx]);
        RamBusDataOut = rd[idx];
        pend = 1'b1;
      end
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 3) begin
          CmdWrite = wr[idx]; CmdAddress = ad[idx]; CmdData = wd[idx];
        end else begin
          CmdValid = 1'b0;
        end
      end
    end
    RamBusAck = 1'b0;
    checks++;
    if (seen != 3 || idx != 3) begin
      errs++;
      $display("FAIL b2b count: got rsp=%0d acc=%0d want 3 3", seen, idx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_cmd("random", 1'($urandom), AW'($urandom), $urandom, $urandom,
              $urandom_range(0, TO + 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
